// File: rtl/instr_mem_loadable.sv
// ---------------------------------------------------------------------------
// instr_mem_loadable
//   Clocked instruction memory for the RV32I core. It has a byte-addressed,
//   word-aligned fetch port with a one-cycle registered read and a req/valid
//   handshake, and a streaming load port so a boot loader or bench can write
//   the program image.
//   A misaligned or out-of-range fetch returns NOP_WORD and raises fetch_fault.
//   The array holds X until it is loaded through the load port.
//
// Ports
//   clk, rst_n       clock, async active-low reset
//   fetch_req        fetch request (accepted when fetch_ready)
//   fetch_addr       byte address of the instruction
//   fetch_ready      high in RUN
//   fetch_valid      one-cycle pulse, the cycle after an accept
//   fetch_instr      fetched word (holds its value between pulses)
//   fetch_fault      fetch was misaligned or out of range
//   load_start       enter LOAD or restart it, latching load_base
//   load_base        byte address of the first loaded word
//   load_wr          write load_data at the load pointer
//   load_data        word to write
//   load_stop        return to RUN
//   load_busy        high in LOAD
//   load_count       words written since the last load_start
//   load_overflow    sticky, a load write fell outside the array
// ---------------------------------------------------------------------------
module instr_mem_loadable #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 512,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0000_0013)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_req,
    input  logic [ADDR_W-1:0]          fetch_addr,
    output logic                       fetch_ready,
    output logic                       fetch_valid,
    output logic [DATA_W-1:0]          fetch_instr,
    output logic                       fetch_fault,
    input  logic                       load_start,
    input  logic [ADDR_W-1:0]          load_base,
    input  logic                       load_wr,
    input  logic [DATA_W-1:0]          load_data,
    input  logic                       load_stop,
    output logic                       load_busy,
    output logic [$clog2(DEPTH+1)-1:0] load_count,
    output logic                       load_overflow
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = ADDR_W - 2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              ready_q;
    logic              valid_q;
    logic [DATA_W-1:0] instr_q;
    logic              fault_q;
    logic              mem_we_c;

    // The low two bits of load_base select a byte inside the word and are dropped.
    logic [1:0]        unused_base_lsb;
    assign unused_base_lsb = load_base[1:0];

    // Fetch decode
    logic [PTR_W-1:0]  fetch_idx_c;
    logic              fetch_fault_c;
    logic              fetch_accept_c;
    assign fetch_idx_c    = fetch_addr[ADDR_W-1:2];
    assign fetch_fault_c  = (fetch_addr[1:0] != 2'b00) || (fetch_idx_c >= PTR_W'(DEPTH));
    assign fetch_accept_c = fetch_req && ready_q;

    // Next state for the control FSM, load pointer, count and overflow flag
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        mem_we_c = 1'b0;
        if (load_start) begin
            // Enter LOAD, or restart it; load_start takes priority over load_stop.
            state_d = ST_LOAD;
            ptr_d   = load_base[ADDR_W-1:2];
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (state_q == ST_LOAD) begin
            if (load_wr) begin
                if (ptr_q < PTR_W'(DEPTH)) begin
                    mem_we_c = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                // The pointer and count saturate rather than wrapping back into valid addresses.
                if (ptr_q != '1) ptr_d = ptr_q + PTR_W'(1);
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end
            if (load_stop) state_d = ST_RUN;
        end
    end

    // Control and fetch output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            instr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ready_q <= (state_d == ST_RUN);
            valid_q <= fetch_accept_c;
            if (fetch_accept_c) begin
                instr_q <= fetch_fault_c ? NOP_WORD : mem[fetch_idx_c[IDX_W-1:0]];
                fault_q <= fetch_fault_c;
            end
        end
    end

    // The storage array has no reset, so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[ptr_q[IDX_W-1:0]] <= load_data;
    end

    assign fetch_ready   = ready_q;
    assign fetch_valid   = valid_q;
    assign fetch_instr   = instr_q;
    assign fetch_fault   = fault_q;
    assign load_busy     = (state_q == ST_LOAD);
    assign load_count    = cnt_q;
    assign load_overflow = ovf_q;

endmodule
